// File: rtl/adder_pkg.sv
// Shared adder/subtractor definitions: operation encoding and small decode helpers,
// also used by the ALU control decode.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBB = 2'b11
  } add_op_e;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic logic op_inverts_b(input add_op_e op);
    return (op == OP_SUB) || (op == OP_SUBB);
  endfunction

  // Subtraction without borrow-in is a + ~b + 1, so SUB forces the initial carry high.
  function automatic logic op_carry_in(input add_op_e op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry chain; also exposes the carry entering its MSB
// so the final segment can derive signed overflow.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  for (genvar i = 0; i < SEG; i++) begin : gen_bit
    logic ci;
    logic co;

    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_chain
      assign ci = gen_bit[i-1].co;
    end

    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign cout = gen_bit[SEG-1].co;
  assign cmsb = gen_bit[SEG-1].ci;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the building block of every ripple segment.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES registered segments with a shared
// valid/ready stall, carry/overflow/zero flags computed in the last segment.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic    adv;
  add_op_e op_e;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign op_e     = add_op_e'(op);

  // Stage k keeps only the operand bits not yet added and the sum bits already produced,
  // so the register footprint shrinks on one side as it grows on the other.
  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    a_in;
    logic [REM-1:0]    b_in;
    logic              c_in;
    logic              v_in;
    logic [LO+SEG-1:0] s_new;
    logic [SEG-1:0]    seg_sum;
    logic              seg_cout;
    logic              seg_cmsb;
    logic              v_q;
    logic              c_q;
    logic [LO+SEG-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_in  = operand1;
      assign b_in  = op_inverts_b(op_e) ? ~operand2 : operand2;
      assign c_in  = op_carry_in(op_e, cin);
      assign v_in  = in_valid;
      assign s_new = seg_sum;
    end else begin : g_body
      assign a_in  = gen_stage[k-1].g_fwd.a_q;
      assign b_in  = gen_stage[k-1].g_fwd.b_q;
      assign c_in  = gen_stage[k-1].c_q;
      assign v_in  = gen_stage[k-1].v_q;
      assign s_new = {seg_sum, gen_stage[k-1].s_q};
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (a_in[SEG-1:0]),
      .b    (b_in[SEG-1:0]),
      .cin  (c_in),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= seg_cout;
        s_q <= s_new;
      end
    end

    if (REM > SEG) begin : g_fwd
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= seg_cmsb ^ seg_cout;
          zero_q <= (s_new == '0);
        end
      end
    end else begin : g_mid
      logic cmsb_unused;
      assign cmsb_unused = seg_cmsb;
    end
  end

  assign out_valid = gen_stage[STAGES-1].v_q;
  assign sum       = gen_stage[STAGES-1].s_q;
  assign cout      = gen_stage[STAGES-1].c_q;
  assign overflow  = gen_stage[STAGES-1].g_flags.ovf_q;
  assign zero      = gen_stage[STAGES-1].g_flags.zero_q;

endmodule
